// File: rtl/sta_reg_pipe.sv
// Parametrised reg -> combine -> DEPTH-stage register timing path with valid, hold and a saturating sample counter.
// Optional out_parity port when STA_REG_PIPE_PARITY_EN is defined.
module sta_reg_pipe #(
    parameter int WIDTH = 8,
    parameter int NCH   = 2,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                   clk1,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [NCH*WIDTH-1:0]   in_data,
    input  logic [1:0]             mode,
    input  logic                   hold,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [CNT_W-1:0]       out_count
`ifdef STA_REG_PIPE_PARITY_EN
    ,
    output logic                   out_parity
`endif
);

    typedef enum logic [1:0] {
        MODE_AND = 2'b00,
        MODE_OR  = 2'b01,
        MODE_XOR = 2'b10,
        MODE_AOI = 2'b11
    } mode_t;

    logic [WIDTH-1:0] r_ch [NCH];
    mode_t            r_mode;
    logic [DEPTH:0]   r_v;
    logic [WIDTH-1:0] r_pd [1:DEPTH];
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_or;
    logic [WIDTH-1:0] w_xor;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_comb;
    logic [WIDTH-1:0] w_last_in;

    always_comb begin
        w_and = '1;
        w_or  = '0;
        w_xor = '0;
        w_hi  = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            w_and = w_and & r_ch[c];
            w_or  = w_or  | r_ch[c];
            w_xor = w_xor ^ r_ch[c];
        end
        for (int unsigned c = 2; c < NCH; c++) begin
            w_hi = w_hi | r_ch[c];
        end
        case (r_mode)
            MODE_AND: w_comb = w_and;
            MODE_OR:  w_comb = w_or;
            MODE_XOR: w_comb = w_xor;
            default:  w_comb = ~((r_ch[0] & r_ch[1]) | w_hi);
        endcase
    end

    // Value about to enter the final stage; feeds the output parity register.
    generate
        if (DEPTH == 1) begin : g_last_d1
            assign w_last_in = w_comb;
        end else begin : g_last_dn
            assign w_last_in = r_pd[DEPTH-1];
        end
    endgenerate

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_mode <= MODE_AND;
            r_v    <= '0;
            r_cnt  <= '0;
            for (int unsigned c = 0; c < NCH; c++) begin
                r_ch[c] <= '0;
            end
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                r_pd[k] <= '0;
            end
        end else if (!hold) begin
            r_v <= {r_v[DEPTH-1:0], in_valid};
            if (in_valid) begin
                r_mode <= mode_t'(mode);
                for (int unsigned c = 0; c < NCH; c++) begin
                    r_ch[c] <= in_data[c*WIDTH +: WIDTH];
                end
            end
            r_pd[1] <= w_comb;
            for (int unsigned k = 2; k <= DEPTH; k++) begin
                r_pd[k] <= r_pd[k-1];
            end
            // Count advances together with the output stage so out_count already includes the visible sample.
            if (r_v[DEPTH-1] && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef STA_REG_PIPE_PARITY_EN
    logic r_par;

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_par <= 1'b0;
        end else if (!hold) begin
            r_par <= ^w_last_in;
        end
    end

    assign out_parity = r_par;
`else
    logic w_unused_last;
    assign w_unused_last = ^w_last_in;
`endif

    assign out_valid = r_v[DEPTH];
    assign out_data  = r_pd[DEPTH];
    assign out_count = r_cnt;

endmodule

// File: tb/tb_sta_reg_pipe.sv
// Directed self-checking bench for sta_reg_pipe: default, small-counter and 4-channel/depth-1 instances.
module tb_sta_reg_pipe;

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Instance A: defaults
    logic        a_in_valid = 1'b0;
    logic [15:0] a_in_data  = '0;
    logic [1:0]  a_mode     = 2'b00;
    logic        a_hold     = 1'b0;
    logic        a_out_valid;
    logic [7:0]  a_out_data;
    logic [15:0] a_out_count;

    // Instance B: CNT_W=4
    logic        b_in_valid = 1'b0;
    logic [15:0] b_in_data  = 16'h3CF0;
    logic        b_out_valid;
    logic [7:0]  b_out_data;
    logic [3:0]  b_out_count;

    // Instance C: NCH=4, DEPTH=1
    logic        c_in_valid = 1'b0;
    logic [31:0] c_in_data  = '0;
    logic [1:0]  c_mode     = 2'b00;
    logic        c_out_valid;
    logic [7:0]  c_out_data;
    logic [15:0] c_out_count;

`ifdef STA_REG_PIPE_PARITY_EN
    logic a_out_parity;
    logic b_out_parity;
    logic c_out_parity;
`endif

    sta_reg_pipe #(.WIDTH(8), .NCH(2), .DEPTH(2), .CNT_W(16)) u_a (
        .clk1(clk1), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data),
        .mode(a_mode), .hold(a_hold), .out_valid(a_out_valid),
        .out_data(a_out_data), .out_count(a_out_count)
`ifdef STA_REG_PIPE_PARITY_EN
        , .out_parity(a_out_parity)
`endif
    );

    sta_reg_pipe #(.WIDTH(8), .NCH(2), .DEPTH(2), .CNT_W(4)) u_b (
        .clk1(clk1), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data),
        .mode(2'b01), .hold(1'b0), .out_valid(b_out_valid),
        .out_data(b_out_data), .out_count(b_out_count)
`ifdef STA_REG_PIPE_PARITY_EN
        , .out_parity(b_out_parity)
`endif
    );

    sta_reg_pipe #(.WIDTH(8), .NCH(4), .DEPTH(1), .CNT_W(16)) u_c (
        .clk1(clk1), .rst(rst), .in_valid(c_in_valid), .in_data(c_in_data),
        .mode(c_mode), .hold(1'b0), .out_valid(c_out_valid),
        .out_data(c_out_data), .out_count(c_out_count)
`ifdef STA_REG_PIPE_PARITY_EN
        , .out_parity(c_out_parity)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    initial begin
        int valid_seen;
        int sat_bad;

        // Reset for two cycles
        tick();
        tick();
        chk("rst_valid", {31'd0, a_out_valid}, 32'd0);
        chk("rst_data",  {24'd0, a_out_data},  32'd0);
        chk("rst_count", {16'd0, a_out_count}, 32'd0);
        rst = 1'b0;

        // Latency: AND of F0/3C appears on the third edge
        a_in_valid = 1'b1; a_in_data = 16'h3CF0; a_mode = 2'b00;
        tick();
        a_in_valid = 1'b0;
        chk("lat_e0_valid", {31'd0, a_out_valid}, 32'd0);
        tick();
        chk("lat_e1_valid", {31'd0, a_out_valid}, 32'd0);
        tick();
        chk("lat_valid", {31'd0, a_out_valid}, 32'd1);
        chk("lat_data",  {24'd0, a_out_data},  32'h30);
        chk("lat_count", {16'd0, a_out_count}, 32'd1);
        tick();
        chk("bubble_valid", {31'd0, a_out_valid}, 32'd0);
        chk("bubble_data",  {24'd0, a_out_data},  32'h30);

        // Modes back-to-back
        a_in_valid = 1'b1;
        a_mode = 2'b01; tick();
        a_mode = 2'b10; tick();
        a_mode = 2'b11; tick();
        a_in_valid = 1'b0;
        chk("or_valid", {31'd0, a_out_valid}, 32'd1);
        chk("or_data",  {24'd0, a_out_data},  32'hFC);
        chk("or_count", {16'd0, a_out_count}, 32'd2);
        tick();
        chk("xor_valid", {31'd0, a_out_valid}, 32'd1);
        chk("xor_data",  {24'd0, a_out_data},  32'hCC);
        chk("xor_count", {16'd0, a_out_count}, 32'd3);
        tick();
        chk("aoi_valid", {31'd0, a_out_valid}, 32'd1);
        chk("aoi_data",  {24'd0, a_out_data},  32'hCF);
        chk("aoi_count", {16'd0, a_out_count}, 32'd4);
        tick();
        chk("post_mode_valid", {31'd0, a_out_valid}, 32'd0);

        // Hold with one sample in flight: XOR of AA/0F = A5
        a_in_valid = 1'b1; a_in_data = 16'h0FAA; a_mode = 2'b10;
        tick();
        a_in_valid = 1'b0;
        tick();
        a_hold = 1'b1;
        a_in_valid = 1'b1; a_in_data = 16'h2211; a_mode = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_valid", {31'd0, a_out_valid}, 32'd0);
            chk("hold_data",  {24'd0, a_out_data},  32'hCF);
            chk("hold_count", {16'd0, a_out_count}, 32'd4);
        end
        a_hold = 1'b0;
        a_in_valid = 1'b0;
        tick();
        chk("hold_out_valid", {31'd0, a_out_valid}, 32'd1);
        chk("hold_out_data",  {24'd0, a_out_data},  32'hA5);
        chk("hold_out_count", {16'd0, a_out_count}, 32'd5);
        valid_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (a_out_valid) valid_seen++;
        end
        chk("hold_no_capture", valid_seen, 32'd0);
        chk("hold_final_count", {16'd0, a_out_count}, 32'd5);

        // Reset has priority over hold with samples in flight
        a_in_valid = 1'b1; a_in_data = 16'hFFFF; a_mode = 2'b00;
        tick();
        tick();
        a_in_valid = 1'b0;
        rst = 1'b1; a_hold = 1'b1;
        tick();
        chk("rstpri_valid", {31'd0, a_out_valid}, 32'd0);
        chk("rstpri_data",  {24'd0, a_out_data},  32'd0);
        chk("rstpri_count", {16'd0, a_out_count}, 32'd0);
        rst = 1'b0; a_hold = 1'b0;
        valid_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (a_out_valid) valid_seen++;
        end
        chk("rstpri_no_stale", valid_seen, 32'd0);
        chk("rstpri_data_after", {24'd0, a_out_data}, 32'd0);

        // Counter saturation on the CNT_W=4 instance
        b_in_valid = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("sat_mid_count", {28'd0, b_out_count}, 32'd8);
        sat_bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (b_out_count == 4'd15 && i < 5) sat_bad = sat_bad;
        end
        b_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (b_out_count != 4'd15) sat_bad++;
        end
        chk("sat_final_count", {28'd0, b_out_count}, 32'd15);
        chk("sat_held", sat_bad, 32'd0);

        // Configuration sweep: NCH=4, DEPTH=1, AOI
        c_in_valid = 1'b1; c_in_data = 32'h00010FFF; c_mode = 2'b11;
        tick();
        c_in_valid = 1'b0;
        chk("cfg_e0_valid", {31'd0, c_out_valid}, 32'd0);
        tick();
        chk("cfg_valid", {31'd0, c_out_valid}, 32'd1);
        chk("cfg_data",  {24'd0, c_out_data},  32'hF0);
        chk("cfg_count", {16'd0, c_out_count}, 32'd1);
`ifdef STA_REG_PIPE_PARITY_EN
        chk("cfg_parity", {31'd0, c_out_parity}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
